// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage responder that performs one 32-bit word access as
// two 16-bit phases (low half, then high half) on an asynchronous SRAM.
// Each phase lasts WAIT_CYCLES clocks.
//
// Optional feature macro: SRAM_READ_BUF_EN
//   Adds a one-word read buffer. A read that hits the buffer completes
//   without any SRAM activity.
//
// Handshake: ready is combinational and is high only when the block is idle
// with no request (state IDLE, req low) or in the single DONE cycle.
// While ready is low, the pipeline holds mem_read, mem_write, address and
// wdata stable. DONE always returns to IDLE, so a request that is still
// present after DONE is treated as a new access.
//
// Debug: dbg_state_o exposes the FSM state (0=IDLE, 1=LOW, 2=HIGH, 3=DONE).
module sram_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_W-1:0]      address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n,
    output logic [1:0]             dbg_state_o
);

    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WORD_W = SRAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         lo_q, lo_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                req;
    logic                req_wr;
    logic [WORD_W-1:0]   req_word;
    logic                cnt_last;

    // Byte-lane bits and address bits above the SRAM range are ignored.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{address[ADDR_W-1:SRAM_ADDR_W+1], address[1:0]};

    // A simultaneous read and write is treated as a read.
    assign req      = mem_read | mem_write;
    assign req_wr   = mem_write & ~mem_read;
    assign req_word = address[SRAM_ADDR_W:2];
    assign cnt_last = (cnt_q == CNT_LAST);

`ifdef SRAM_READ_BUF_EN
    logic                buf_valid_q, buf_valid_d;
    logic [WORD_W-1:0]   buf_tag_q, buf_tag_d;
    logic [31:0]         buf_data_q, buf_data_d;
    logic                buf_hit;

    assign buf_hit = ~req_wr & buf_valid_q & (buf_tag_q == req_word);
`endif

    // Next-state logic: phase sequencing, wait counter and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
`ifdef SRAM_READ_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    is_wr_d = req_wr;
                    word_d  = req_word;
                    wdata_d = wdata;
`ifdef SRAM_READ_BUF_EN
                    if (buf_hit) begin
                        state_d = DONE;
                        rdata_d = buf_data_q;
                    end else begin
                        state_d = LOW;
                    end
`else
                    state_d = LOW;
`endif
                end
            end
            LOW: begin
                if (cnt_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!is_wr_q) begin
                        lo_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // rdata changes only once both halves are in hand.
                    if (!is_wr_q) begin
                        rdata_d = {sram_dq_in, lo_q};
`ifdef SRAM_READ_BUF_EN
                        buf_valid_d = 1'b1;
                        buf_tag_d   = word_q;
                        buf_data_d  = {sram_dq_in, lo_q};
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
`ifdef SRAM_READ_BUF_EN
                // Keep the buffer coherent with a store to the buffered word.
                if (is_wr_q && buf_valid_q && (buf_tag_q == word_q)) begin
                    buf_data_d = wdata_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SRAM_READ_BUF_EN
    // Read buffer registers; reset only needs to invalidate the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

    // SRAM pin drive: active only in LOW/HIGH. we_n releases on the last
    // cycle of each phase so address and data are held past the strobe.
    always_comb begin
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        if (state_q == LOW || state_q == HIGH) begin
            sram_addr = {word_q, (state_q == HIGH)};
            if (is_wr_q) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = cnt_last;
                sram_dq_out = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
            end
        end
    end

    assign ready       = ((state_q == IDLE) & ~req) | (state_q == DONE);
    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl (WAIT_CYCLES=4): directed table, hand sequences
// for back-to-back and mid-access reset, then random accesses checked
// against a word-level reference memory.
module tb_sram_mem_ctrl;

    localparam int W = 4;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    sram_mem_ctrl #(.ADDR_W(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- SRAM device model ----------------
    function automatic logic [15:0] init_half(input int h);
        return 16'(h * 257) ^ 16'h5A5A;
    endfunction

    logic [15:0] dev_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) dev_mem[i] = init_half(i);
    end
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) dev_mem[sram_addr[7:0]] <= sram_dq_out;
    end
    assign sram_dq_in = dev_mem[sram_addr[7:0]];

    // ---------------- reference model ----------------
    logic [31:0] ref_words [int];
    logic [31:0] last_rdata = '0;
    logic [31:0] exp_q [$];
    bit          mb_valid = 1'b0;
    int          mb_tag   = 0;

    function automatic logic [31:0] ref_read(input int w);
        if (ref_words.exists(w)) return ref_words[w];
        return {init_half(2 * w + 1), init_half(2 * w)};
    endfunction

    function automatic logic [36:0] pins(input logic r, input logic we, input logic oe,
                                         input logic [17:0] a, input logic [15:0] d);
        return {r, we, oe, a, d};
    endfunction

    function automatic logic [36:0] obs();
        return {ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Issues one access; inputs stay asserted through the DONE cycle.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input string tag);
        bit          is_wr;
        bit          hit;
        int          w;
        int          ph;
        int          c;
        logic [15:0] exp_dq;
        logic [31:0] exp_rd;
        is_wr = wr && !rd;
        w     = int'((addr >> 2) & 32'h1FFFF);
        hit   = 1'b0;
`ifdef SRAM_READ_BUF_EN
        hit = !is_wr && mb_valid && (mb_tag == w);
`endif
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        address   = addr;
        wdata     = wd;
        if (!is_wr) exp_q.push_back(ref_read(w));
        @(negedge clk);
        check({tag, "/req"}, 64'(obs()), 64'(pins(1'b0, 1'b1, 1'b0, 18'h0, 16'h0)));
        if (!hit) begin
            for (int k = 0; k < 2 * W; k++) begin
                @(negedge clk);
                ph     = k / W;
                c      = k % W;
                exp_dq = is_wr ? ((ph == 1) ? wd[31:16] : wd[15:0]) : 16'h0;
                check($sformatf("%s/c%0d", tag, k), 64'(obs()),
                      64'(pins(1'b0, is_wr ? (c == W - 1) : 1'b1, is_wr,
                               18'(w * 2 + ph), exp_dq)));
            end
        end
        @(negedge clk);
        check({tag, "/done"}, 64'(obs()), 64'(pins(1'b1, 1'b1, 1'b0, 18'h0, 16'h0)));
        if (!is_wr) begin
            exp_rd = exp_q.pop_front();
            check({tag, "/rdata"}, 64'(rdata), 64'(exp_rd));
            last_rdata = exp_rd;
            mb_valid   = 1'b1;
            mb_tag     = w;
        end else begin
            check({tag, "/rdata_hold"}, 64'(rdata), 64'(last_rdata));
            ref_words[w] = wd;
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check({tag, "/idle"}, 64'(obs()), 64'(pins(1'b1, 1'b1, 1'b0, 18'h0, 16'h0)));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chk;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit          rd;
        bit          wr;
        int          w;
        logic [31:0] a;
        logic [31:0] d;

        tbl[0] = '{rd: 1'b0, wr: 1'b1, addr: 32'h10,    wd: 32'hDEADBEEF, chk: 1'b0, exp_rdata: 32'h0};
        tbl[1] = '{rd: 1'b1, wr: 1'b0, addr: 32'h10,    wd: 32'h0,        chk: 1'b1, exp_rdata: 32'hDEADBEEF};
        tbl[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'h20,    wd: 32'hFFFFFFFF, chk: 1'b1,
                   exp_rdata: {init_half(17), init_half(16)}};
        tbl[3] = '{rd: 1'b0, wr: 1'b1, addr: 32'h24,    wd: 32'h12345678, chk: 1'b0, exp_rdata: 32'h0};
        tbl[4] = '{rd: 1'b1, wr: 1'b0, addr: 32'h80024, wd: 32'h0,        chk: 1'b1, exp_rdata: 32'h12345678};
        tbl[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'h13,    wd: 32'h0,        chk: 1'b1, exp_rdata: 32'hDEADBEEF};

        // ---- reset ----
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        address   = '0;
        wdata     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/pins", 64'(obs()), 64'(pins(1'b1, 1'b1, 1'b0, 18'h0, 16'h0)));
        check("reset/rdata", 64'(rdata), 64'h0);
        check("reset/state", 64'(dbg_state), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < 6; i++) begin
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, $sformatf("tbl%0d", i));
            if (tbl[i].chk) check($sformatf("tbl%0d/const", i), 64'(rdata), 64'(tbl[i].exp_rdata));
            idle_cycle($sformatf("tbl%0d", i));
        end

        // ---- back-to-back: read then write, request held through DONE ----
        run_access(1'b1, 1'b0, 32'h30, 32'h0, "b2b_rd");
        run_access(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, "b2b_wr");
        idle_cycle("b2b");

        // ---- reset in the HIGH phase of a write ----
        @(posedge clk); #1;
        mem_write = 1'b1;
        address   = 32'h100;
        wdata     = 32'hA5A5_5A5A;
        repeat (1 + W + 2) @(negedge clk);
        check("rst_mid/in_high", 64'(sram_addr), 64'h81);
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid/pins", 64'(obs()), 64'(pins(1'b1, 1'b1, 1'b0, 18'h0, 16'h0)));
        check("rst_mid/rdata", 64'(rdata), 64'h0);
        last_rdata = '0;
        mb_valid   = 1'b0;

`ifdef SRAM_READ_BUF_EN
        // ---- read buffer: repeat read hits, store keeps buffer coherent ----
        run_access(1'b1, 1'b0, 32'h10, 32'h0, "buf_rd1");
        idle_cycle("buf1");
        run_access(1'b1, 1'b0, 32'h10, 32'h0, "buf_rd2");
        check("buf_rd2/const", 64'(rdata), 64'hDEADBEEF);
        idle_cycle("buf2");
        run_access(1'b0, 1'b1, 32'h10, 32'h1, "buf_wr");
        idle_cycle("buf3");
        run_access(1'b1, 1'b0, 32'h10, 32'h0, "buf_rd3");
        check("buf_rd3/const", 64'(rdata), 64'h1);
        idle_cycle("buf4");
`endif

        // ---- random accesses over 16 words with random upper address bits ----
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            w  = $urandom_range(0, 15);
            a  = ($urandom & 32'hFFF8_0000) | 32'(w << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            run_access(rd, wr, a, d, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rnd%0d", i));
        end
        idle_cycle("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
